// File: rtl/ladybird_uart_bus_master.sv
// ladybird_uart_bus_master
//   Host-side loader/debug bridge. Parses a byte stream from the UART receive
//   side into word-wide bus transactions and returns replies on the UART
//   transmit side.
//
//   Command format (little-endian, NB = XLEN/8):
//     'W' (0x57) + NB addr bytes + NB data bytes -> write, reply 0x06
//     'R' (0x52) + NB addr bytes                 -> read,  reply NB rdata bytes
//     anything else                              -> reply 0x15
//
// Ports:
//   clk, arst            clock, asynchronous active-high reset
//   rx_data/valid/ready  command byte stream in
//   tx_data/valid/ready  reply byte stream out
//   req/gnt              bus request handshake (initiator side)
//   addr/wstrb/wdata     bus request payload; wstrb all ones = write, 0 = read
//   rdata/data_gnt       read data return
//   busy                 high whenever not idle
module ladybird_uart_bus_master #(
    parameter int          XLEN    = 32,
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              req,
    input  logic              gnt,
    output logic [XLEN-1:0]   addr,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    input  logic              data_gnt,
    output logic              busy
);

    localparam int            NB   = XLEN / 8;
    localparam int            CW   = $clog2(NB) + 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [CW-1:0]   byte_cnt;
    logic [23:0]     tmo_cnt;
    logic [XLEN-1:0] rsp_sr;
    logic            is_wr;
    logic            rsp_one;   // reply is a single ACK/NAK byte

    logic            rx_fire;
    logic            tx_fire;
    logic            tmo_hit;
    logic [XLEN-1:0] rx_shift_addr;
    logic [XLEN-1:0] rx_shift_data;
    logic [XLEN-1:0] rsp_next;

    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;

    // Fires on the idle cycle that would make the count reach TIMEOUT.
    assign tmo_hit = (TIMEOUT != 24'd0) && (tmo_cnt >= TIMEOUT - 24'd1);

    // Little-endian fields: each new byte enters at the top and earlier bytes
    // move down, so the first byte received ends up in bits [7:0].
    assign rx_shift_addr = (addr  >> 8) | (XLEN'(rx_data) << (XLEN - 8));
    assign rx_shift_data = (wdata >> 8) | (XLEN'(rx_data) << (XLEN - 8));
    assign rsp_next      = rsp_sr >> 8;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= S_IDLE;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            rsp_sr   <= '0;
            is_wr    <= 1'b0;
            rsp_one  <= 1'b0;
            rx_ready <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            req      <= 1'b0;
            addr     <= '0;
            wstrb    <= '0;
            wdata    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rx_ready <= 1'b1;
                    byte_cnt <= '0;
                    tmo_cnt  <= '0;
                    if (rx_fire) begin
                        busy <= 1'b1;
                        if (rx_data == CMD_W || rx_data == CMD_R) begin
                            is_wr <= (rx_data == CMD_W);
                            state <= S_ADDR;
                        end else begin
                            rx_ready <= 1'b0;
                            tx_valid <= 1'b1;
                            tx_data  <= NAK;
                            rsp_one  <= 1'b1;
                            state    <= S_RESP;
                        end
                    end
                end

                S_ADDR: begin
                    if (rx_fire) begin
                        tmo_cnt <= '0;
                        addr    <= rx_shift_addr;
                        if (byte_cnt == LAST) begin
                            byte_cnt <= '0;
                            if (is_wr) begin
                                state <= S_DATA;
                            end else begin
                                rx_ready <= 1'b0;
                                req      <= 1'b1;
                                wstrb    <= '0;
                                state    <= S_BUS_REQ;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end else if (tmo_hit) begin
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
                end

                S_DATA: begin
                    if (rx_fire) begin
                        tmo_cnt <= '0;
                        wdata   <= rx_shift_data;
                        if (byte_cnt == LAST) begin
                            byte_cnt <= '0;
                            rx_ready <= 1'b0;
                            req      <= 1'b1;
                            wstrb    <= '1;
                            state    <= S_BUS_REQ;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end else if (tmo_hit) begin
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
                end

                S_BUS_REQ: begin
                    tmo_cnt <= '0;
                    // req and payload hold until accepted; never withdrawn.
                    if (gnt) begin
                        req      <= 1'b0;
                        wstrb    <= '0;
                        byte_cnt <= '0;
                        if (is_wr) begin
                            tx_valid <= 1'b1;
                            tx_data  <= ACK;
                            rsp_one  <= 1'b1;
                            state    <= S_RESP;
                        end else if (data_gnt) begin
                            // Grant and data in the same cycle: skip the wait.
                            rsp_sr   <= rdata;
                            tx_valid <= 1'b1;
                            tx_data  <= rdata[7:0];
                            rsp_one  <= 1'b0;
                            state    <= S_RESP;
                        end else begin
                            state <= S_BUS_WAIT;
                        end
                    end
                end

                S_BUS_WAIT: begin
                    tmo_cnt <= '0;
                    if (data_gnt) begin
                        byte_cnt <= '0;
                        rsp_sr   <= rdata;
                        tx_valid <= 1'b1;
                        tx_data  <= rdata[7:0];
                        rsp_one  <= 1'b0;
                        state    <= S_RESP;
                    end
                end

                S_RESP: begin
                    tmo_cnt <= '0;
                    if (tx_fire) begin
                        if (rsp_one || byte_cnt == LAST) begin
                            byte_cnt <= '0;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            rx_ready <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                            rsp_sr   <= rsp_next;
                            tx_data  <= rsp_next[7:0];
                        end
                    end
                end

                default: begin
                    req      <= 1'b0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    rx_ready <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ladybird_uart_bus_master.sv
// Scoreboard bench for ladybird_uart_bus_master. Stimulus tasks push the
// expected bus transaction and reply bytes into queues; independent monitors
// pop and compare whenever the DUT performs a bus handshake or a tx handshake.
module tb_ladybird_uart_bus_master;

    logic        clk = 1'b0;
    logic        arst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        data_gnt;
    logic        busy;

    ladybird_uart_bus_master #(.XLEN(32), .TIMEOUT(24'd100)) dut (
        .clk(clk), .arst(arst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .req(req), .gnt(gnt), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .rdata(rdata), .data_gnt(data_gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        bit          chk_d;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] tx_q[$];

    int checks = 0;
    int fails  = 0;

    // Responder / sink knobs
    int          gnt_dly  = 0;
    int          dg_dly   = 0;
    int          tx_stall = 0;
    int          gap_max  = 0;
    logic [31:0] rd_val   = 32'h0;

    // ---------------- bus responder ----------------
    initial begin : responder
        int   w;
        logic rd;
        gnt = 1'b0; data_gnt = 1'b0; rdata = '0;
        forever begin
            @(posedge clk); #1;
            gnt = 1'b0; data_gnt = 1'b0; rdata = $urandom;
            if (req && !arst) begin
                w = 0;
                while (w < gnt_dly && req) begin
                    @(posedge clk); #1;
                    rdata = $urandom;
                    w++;
                end
                if (req) begin
                    rd  = (wstrb == 4'h0);
                    gnt = 1'b1;
                    if (rd && dg_dly == 0) begin
                        data_gnt = 1'b1;
                        rdata    = rd_val;
                    end
                    @(posedge clk); #1;
                    gnt = 1'b0; data_gnt = 1'b0; rdata = $urandom;
                    if (rd && dg_dly > 0) begin
                        for (int k = 1; k < dg_dly; k++) begin
                            @(posedge clk); #1;
                            rdata = $urandom;
                        end
                        data_gnt = 1'b1;
                        rdata    = rd_val;
                        @(posedge clk); #1;
                        data_gnt = 1'b0; rdata = $urandom;
                    end
                end
            end
        end
    end

    // ---------------- tx sink with programmable back-pressure ----------------
    initial begin : tx_sink
        int cnt;
        cnt = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_valid) begin
                if (cnt >= tx_stall) begin
                    tx_ready = 1'b1;
                    cnt = 0;
                end else begin
                    tx_ready = 1'b0;
                    cnt++;
                end
            end else begin
                tx_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // ---------------- monitors ----------------
    logic        req_pend = 0, bus_unstable = 0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    logic        tx_pend = 0, tx_unstable = 0, rxr_bad = 0;
    logic [7:0]  p_tx;

    always @(negedge clk) begin
        if (arst) begin
            req_pend = 0; bus_unstable = 0;
            tx_pend = 0; tx_unstable = 0; rxr_bad = 0;
        end else begin
            // bus side
            if (req) begin
                if (req_pend && (addr != p_addr || wstrb != p_wstrb || wdata != p_wdata))
                    bus_unstable = 1;
                p_addr = addr; p_wstrb = wstrb; p_wdata = wdata;
                if (rx_ready) bus_unstable = 1;
                if (gnt) begin
                    checks++;
                    if (bus_q.size() == 0) begin
                        fails++;
                        $display("FAIL bus_unexpected: got req addr=%h wstrb=%h, required no request", addr, wstrb);
                    end else begin
                        bus_t e;
                        e = bus_q.pop_front();
                        if (addr != e.a || wstrb != e.s || (e.chk_d && wdata != e.d) || bus_unstable) begin
                            fails++;
                            $display("FAIL bus_txn: got addr=%h wstrb=%h wdata=%h unstable=%0b, required addr=%h wstrb=%h wdata=%h unstable=0",
                                     addr, wstrb, wdata, bus_unstable, e.a, e.s, e.d);
                        end
                    end
                    req_pend = 0; bus_unstable = 0;
                end else begin
                    req_pend = 1;
                end
            end else begin
                if (req_pend) begin
                    checks++; fails++;
                    $display("FAIL req_withdrawn: got req=0 before gnt, required req=1");
                end
                req_pend = 0; bus_unstable = 0;
            end
            // tx side
            if (tx_valid) begin
                if (tx_pend && tx_data != p_tx) tx_unstable = 1;
                if (rx_ready) rxr_bad = 1;
                if (tx_ready) begin
                    checks++;
                    if (tx_q.size() == 0) begin
                        fails++;
                        $display("FAIL tx_unexpected: got byte %h, required none", tx_data);
                    end else begin
                        logic [7:0] eb;
                        eb = tx_q.pop_front();
                        if (tx_data != eb || tx_unstable || rxr_bad) begin
                            fails++;
                            $display("FAIL tx_byte: got %h unstable=%0b rx_ready_seen=%0b, required %h unstable=0 rx_ready_seen=0",
                                     tx_data, tx_unstable, rxr_bad, eb);
                        end
                    end
                    tx_pend = 0; tx_unstable = 0; rxr_bad = 0;
                end else begin
                    tx_pend = 1;
                    p_tx = tx_data;
                end
            end else begin
                tx_pend = 0; tx_unstable = 0; rxr_bad = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        rx_valid = 1'b0;
        rx_data  = $urandom;
        if (!done) begin
            checks++; fails++;
            $display("FAIL rx_accept: got no rx_ready for byte %h, required accept", b);
        end
        if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus_q.push_back('{a, 4'hF, d, 1'b1});
        tx_q.push_back(8'h06);
        send_byte(8'h57);
        send_word(a);
        send_word(d);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] v);
        rd_val = v;
        bus_q.push_back('{a, 4'h0, 32'h0, 1'b0});
        for (int i = 0; i < 4; i++) tx_q.push_back(8'((v >> (8 * i)) & 32'hFF));
        send_byte(8'h52);
        send_word(a);
    endtask

    task automatic do_bad(input logic [7:0] c);
        tx_q.push_back(8'h15);
        send_byte(c);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (!busy && tx_q.size() == 0 && bus_q.size() == 0) ok = 1;
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_idle: got busy=%0b pending_tx=%0d pending_bus=%0d, required 0/0/0",
                     tag, busy, tx_q.size(), bus_q.size());
            tx_q.delete(); bus_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0b, required %0b", tag, got, exp);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] ra, rd;
        int          kind;
        arst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        check_bit("rst_req", req, 1'b0);
        check_bit("rst_tx_valid", tx_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_rx_ready", rx_ready, 1'b0);
        checks++;
        if (addr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0 || tx_data !== 8'h0) begin
            fails++;
            $display("FAIL rst_regs: got addr=%h wdata=%h wstrb=%h tx_data=%h, required zeros",
                     addr, wdata, wstrb, tx_data);
        end
        @(negedge clk); arst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Directed write, immediate grant
        gnt_dly = 0; tx_stall = 0; gap_max = 0;
        tx_q.push_back(8'h06);
        bus_q.push_back('{32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1'b1});
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_idle("wr");

        // Read with delayed grant and delayed data, plus back-pressure on reply
        gnt_dly = 5; dg_dly = 3; tx_stall = 10;
        do_read(32'h0000_0004, 32'h1234_5678);
        wait_idle("rd_stall");

        // Bad command
        tx_stall = 0;
        do_bad(8'h41);
        wait_idle("bad");

        // Timeout in the middle of an address field
        send_byte(8'h57);
        send_byte(8'h01);
        check_bit("tmo_busy_before", busy, 1'b1);
        repeat (110) @(posedge clk);
        @(negedge clk);
        check_bit("tmo_busy_after", busy, 1'b0);
        check_bit("tmo_rx_ready", rx_ready, 1'b1);
        @(posedge clk); #1;
        gnt_dly = 1; dg_dly = 2;
        do_read(32'hA5A5_0010, 32'hCAFE_F00D);
        wait_idle("after_tmo");

        // Same-cycle gnt and data_gnt
        gnt_dly = 0; dg_dly = 0;
        do_read(32'h0000_0200, 32'h8899_AABB);
        wait_idle("same_cycle");

        // Reset while sitting in BUS_REQ
        gnt_dly = 60;
        do_write(32'h0000_0300, 32'h0BAD_F00D);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (req) seen = 1;
            end
            check_bit("rst_mid_req_seen", seen, 1'b1);
        end
        @(posedge clk); #3;
        arst = 1'b1;
        #1;
        check_bit("arst_req", req, 1'b0);
        check_bit("arst_tx_valid", tx_valid, 1'b0);
        check_bit("arst_busy", busy, 1'b0);
        tx_q.delete(); bus_q.delete();
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;
        gnt_dly = 0;
        repeat (2) @(posedge clk); #1;
        do_write(32'h0000_0304, 32'h1357_9BDF);
        wait_idle("after_rst");

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            gnt_dly  = $urandom_range(4, 0);
            dg_dly   = $urandom_range(4, 0);
            tx_stall = $urandom_range(3, 0);
            gap_max  = $urandom_range(3, 0);
            ra       = $urandom;
            rd       = $urandom;
            kind     = $urandom_range(9, 0);
            if (kind < 4) begin
                do_write(ra, rd);
            end else if (kind < 8) begin
                do_read(ra, rd);
            end else begin
                logic [7:0] c;
                c = 8'($urandom);
                if (c == 8'h57 || c == 8'h52) c = 8'h00;
                do_bad(c);
            end
            wait_idle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no completion, required finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ladybird_uart_bus_master.md
Name: ladybird_uart_bus_master

Overview:
- Host-side debug/loader bridge: consumes the byte stream from the serial interface's receive side and drives word-wide bus transactions as a bus initiator.
- Provides the initiator end of the request/grant data-bus protocol that the top-level UART-mapped responder serves; used to load IRAM and to peek or poke memory from a PC.
- Replies go out on the serial interface's transmit side.

Parameters:
- XLEN, 32, bus address/data width (multiple of 8).
- TIMEOUT, 24'd1000000, idle cycles allowed between bytes of one command before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock
- arst  in  1  reset; asynchronous, active-high
- rx_data  in  8  received byte (serial interface o_data)
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte consumed when rx_valid & rx_ready
- tx_data  out  8  reply byte (serial interface i_data)
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  reply byte taken when tx_valid & tx_ready
- req  out  1  bus request
- gnt  in  1  request accepted when req & gnt
- addr  out  XLEN  bus address
- wstrb  out  XLEN/8  byte strobes; all ones = write, all zeros = read
- wdata  out  XLEN  write data
- rdata  in  XLEN  read data
- data_gnt  in  1  rdata valid (reads only)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter and timeout counter 0, address/data shift registers 0. arst mid-transaction aborts at once; no further req is issued; a reply in progress is dropped.
- Command format, all multi-byte fields little-endian, NB = XLEN/8:
  - 0x57 'W': NB address bytes, then NB data bytes. Issues a write with wstrb all ones. Reply is one byte, 0x06.
  - 0x52 'R': NB address bytes. Issues a read. Reply is NB bytes of rdata, LSB first.
  - Any other byte in IDLE: consumed, reply 0x15 (NAK), return to IDLE.
- rx_ready = 1 in IDLE, ADDR and DATA only; 0 in all other states.
- States and transitions:
  - IDLE: a command byte goes to ADDR ('W'/'R') or to RESP with the NAK.
  - ADDR: shift in NB bytes. Last byte goes to DATA for a write, BUS_REQ for a read.
  - DATA: shift in NB bytes. Last byte goes to BUS_REQ.
  - BUS_REQ: req = 1; addr, wstrb, wdata stable until req & gnt.
    - Write accepted: go to RESP with 0x06.
    - Read accepted: go to BUS_WAIT.
    - req is never withdrawn before gnt.
  - BUS_WAIT: req = 0. On data_gnt, latch rdata and go to RESP.
  - RESP: send one byte (write/NAK) or NB bytes (read). tx_valid is held with tx_data stable until tx_ready. After the last byte, return to IDLE.
- Latency:
  - req asserts the cycle after the last command byte handshake.
  - tx_valid asserts the cycle after the write acceptance or after data_gnt.
- Simultaneous events:
  - If gnt and data_gnt occur in the same cycle for a read, capture rdata then; skip BUS_WAIT.
  - data_gnt outside BUS_REQ/BUS_WAIT is ignored.
- Timeout counter:
  - Runs only in ADDR and DATA; clears on every accepted byte.
  - Reaching TIMEOUT returns to IDLE silently (no bus access, no reply) and clears the byte counter.
  - Saturates; it does not wrap.
  - No timeout applies in the BUS_* or RESP states.
- Byte counter: log2(NB)+1 bits, clears on every state entry.
- The bus address is used as received; no alignment check.

Test Plan:
- Write: after reset, send 57 00 01 00 00 EF BE AD DE with gnt = 1 -> exactly one cycle of req = 1, addr = 0x00000100, wstrb = 0xF, wdata = 0xDEADBEEF; then tx byte 0x06; busy returns to 0.
- Read with delayed grant: send 52 04 00 00 00, gnt low for 5 cycles, data_gnt 3 cycles after acceptance with rdata = 0x12345678 -> req, addr and wstrb = 0 stable through the stall; tx bytes 78 56 34 12.
- Back-pressure: during the 0x12345678 read reply, hold tx_ready = 0 for 10 cycles per byte -> tx_data stable while tx_valid is high; 4 bytes total; rx_ready = 0 throughout.
- Bad command and timeout: send 0x41 -> reply 0x15. With TIMEOUT = 100, send 57 01 then idle 100 cycles -> return to IDLE, no req; a following full 'R' command works normally.
- Same-cycle grant, and reset: read with gnt and data_gnt in one cycle -> correct 4-byte reply. Assert arst while in BUS_REQ -> req = 0 immediately, tx_valid = 0, busy = 0; the next command executes correctly.
